// File: rtl/whackamole_core.sv
// Whack-a-mole game core: round timer, single-mole spawner driven by a
// free-running LFSR, hit/miss scoring with saturation, optional wrong-press penalty.
//
// state | meaning
// IDLE  | waiting for start after reset
// PLAY  | round running, ticks count down time_left
// OVER  | round finished, results held until next start
module whackamole_core #(
  parameter int          NUM_MOLES  = 5,
  parameter int          SCORE_W    = 6,
  parameter int          GAME_TICKS = 60,
  parameter int          MOLE_LIFE  = 2,
  parameter int          PENALTY_EN = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         TW         = $clog2(GAME_TICKS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   miss_count,
  output logic [TW-1:0]        time_left,
  output logic                 game_active,
  output logic                 game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [3:0]           LAST_IDX  = 4'(NUM_MOLES - 1);
  localparam logic [3:0]           LIFE_INIT = 4'(MOLE_LIFE);
  localparam logic [TW-1:0]        TIME_INIT = TW'(GAME_TICKS);
  localparam logic [NUM_MOLES-1:0] LED_ONE   = NUM_MOLES'(1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;

  state_t               state, state_nxt;
  logic [15:0]          lfsr;
  logic [3:0]           life, life_nxt;
  logic [3:0]           prev_idx, prev_nxt;
  logic [NUM_MOLES-1:0] led_nxt;
  logic [SCORE_W-1:0]   score_nxt, miss_nxt;
  logic [TW-1:0]        time_nxt;
  logic                 hit_ok, wrong_press, last_tick, spawn;
  logic [3:0]           idx_pick, spawn_idx;

  // Candidate spawn position; bumped by one so the same hole never lights twice in a row.
  assign idx_pick  = 4'(lfsr[7:0] % 8'(NUM_MOLES));
  assign spawn_idx = (idx_pick != prev_idx) ? idx_pick :
                     (idx_pick == LAST_IDX) ? 4'd0 : idx_pick + 4'd1;

  // Galois LFSR, taps 16,14,13,11; free-running so spawn positions vary with player timing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Next-state and datapath decisions for the round.
  always_comb begin
    state_nxt   = state;
    led_nxt     = mole_led;
    score_nxt   = score;
    miss_nxt    = miss_count;
    time_nxt    = time_left;
    life_nxt    = life;
    prev_nxt    = prev_idx;
    hit_ok      = |(hit & mole_led);
    wrong_press = (|hit) && !hit_ok;
    last_tick   = tick && (time_left == TW'(1));
    spawn       = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt = PLAY;
          time_nxt  = TIME_INIT;
          score_nxt = '0;
          miss_nxt  = '0;
          led_nxt   = '0;
          life_nxt  = '0;
        end
      end
      PLAY: begin
        if (hit_ok) begin
          if (score != SCORE_MAX) score_nxt = score + SCORE_W'(1);
          led_nxt = '0;
        end else if (wrong_press && (PENALTY_EN != 0) && (score != '0)) begin
          score_nxt = score - SCORE_W'(1);
        end
        if (tick) begin
          time_nxt = time_left - TW'(1);
          // A hit in the same cycle suppresses both the miss and the respawn.
          if (!hit_ok && (mole_led != '0)) begin
            life_nxt = life - 4'd1;
            if (life == 4'd1) begin
              if (miss_count != SCORE_MAX) miss_nxt = miss_count + SCORE_W'(1);
              spawn = !last_tick;
            end
          end else if (!hit_ok) begin
            spawn = !last_tick;
          end
          if (spawn) begin
            led_nxt  = LED_ONE << spawn_idx;
            prev_nxt = spawn_idx;
            life_nxt = LIFE_INIT;
          end
          if (last_tick) begin
            state_nxt = OVER;
            led_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; status flags are registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mole_led    <= '0;
      score       <= '0;
      miss_count  <= '0;
      time_left   <= '0;
      life        <= '0;
      prev_idx    <= '0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      mole_led    <= led_nxt;
      score       <= score_nxt;
      miss_count  <= miss_nxt;
      time_left   <= time_nxt;
      life        <= life_nxt;
      prev_idx    <= prev_nxt;
      game_active <= (state_nxt == PLAY);
      game_over   <= (state_nxt == OVER);
    end
  end

endmodule

// File: tb/tb_whackamole_core.sv
// Self-checking bench for whackamole_core: directed game scenarios followed by
// randomized play, all compared against a round-level reference model.
module tb_whackamole_core;

  localparam int          NM   = 5;
  localparam int          SW   = 3;
  localparam int          GT   = 20;
  localparam int          ML   = 2;
  localparam int          PEN  = 1;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          TW   = $clog2(GT + 1);
  localparam int          SMAX = (1 << SW) - 1;

  logic          clock, reset, start, tick;
  logic [NM-1:0] hit;
  logic [NM-1:0] mole_led;
  logic [SW-1:0] score, miss_count;
  logic [TW-1:0] time_left;
  logic          game_active, game_over;

  int n_checks, n_fail;

  // Reference model: 0=idle 1=play 2=over; m_led is the lit position or -1.
  int          m_state, m_led, m_life, m_score, m_miss, m_time, m_prev;
  logic [15:0] m_lfsr;

  whackamole_core #(
    .NUM_MOLES(NM), .SCORE_W(SW), .GAME_TICKS(GT), .MOLE_LIFE(ML),
    .PENALTY_EN(PEN), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick), .hit(hit),
    .mole_led(mole_led), .score(score), .miss_count(miss_count),
    .time_left(time_left), .game_active(game_active), .game_over(game_over)
  );

  // 100 MHz clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NM-1:0] lit_mask();
    logic [NM-1:0] m;
    m = '0;
    if (m_led >= 0) m[m_led] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_led = -1; m_life = 0; m_score = 0;
    m_miss = 0; m_time = 0; m_prev = 0; m_lfsr = SEED;
  endtask

  task automatic model_spawn(input logic [15:0] l);
    int idx;
    idx = int'(l[7:0]) % NM;
    if (idx == m_prev) idx = (idx + 1) % NM;
    m_led = idx; m_prev = idx; m_life = ML;
  endtask

  task automatic model_step(input logic s, input logic t, input logic [NM-1:0] h);
    logic [15:0] cur;
    logic lit, hit_ok;
    cur = m_lfsr;
    if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_time = GT; m_score = 0; m_miss = 0; m_led = -1; m_life = 0;
      end
    end else begin
      lit = (m_led >= 0);
      hit_ok = lit && h[m_led];
      if (hit_ok) begin
        if (m_score < SMAX) m_score++;
        m_led = -1;
      end else if (h != '0 && PEN == 1) begin
        if (m_score > 0) m_score--;
      end
      if (t) begin
        m_time--;
        if (!hit_ok) begin
          if (lit) begin
            m_life--;
            if (m_life == 0) begin
              if (m_miss < SMAX) m_miss++;
              if (m_time > 0) model_spawn(cur);
            end
          end else if (m_time > 0) begin
            model_spawn(cur);
          end
        end
        if (m_time == 0) begin
          m_state = 2; m_led = -1;
        end
      end
    end
    m_lfsr = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic check_all();
    logic [NM-1:0] exp_led;
    exp_led = lit_mask();
    check("mole_led",    32'(mole_led),    32'(exp_led));
    check("score",       32'(score),       32'(m_score));
    check("miss_count",  32'(miss_count),  32'(m_miss));
    check("time_left",   32'(time_left),   32'(m_time));
    check("game_active", 32'(game_active), 32'(m_state == 1));
    check("game_over",   32'(game_over),   32'(m_state == 2));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model, check after the edge.
  task automatic do_cycle(input logic s, input logic t, input logic [NM-1:0] h);
    start = s; tick = t; hit = h;
    if (reset) model_step(s, t, h);
    else       model_reset();
    @(posedge clock); #1;
    check_all();
    @(negedge clock);
  endtask

  initial begin
    logic [NM-1:0] h, unlit;
    logic s, t;
    int r, sc0;
    clock = 1'b0; reset = 1'b0; start = 1'b0; tick = 1'b0; hit = '0;
    n_checks = 0; n_fail = 0;
    model_reset();
    #2 check_all();
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // Tick and hit without start are ignored.
    do_cycle(1'b0, 1'b1, '1);
    do_cycle(1'b0, 1'b1, NM'(1));

    // Full round with no hits.
    do_cycle(1'b1, 1'b0, '0);
    check("active_after_start", 32'(game_active), 32'd1);
    check("time_after_start", 32'(time_left), 32'(GT));
    for (int i = 0; i < GT + 2; i++) do_cycle(1'b0, 1'b1, '0);
    check("over_after_round", 32'(game_over), 32'd1);
    check("led_clear_over", 32'(mole_led), 32'd0);

    // Hits (with a redundant start) up to saturation.
    do_cycle(1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b1, '0);
    for (int i = 0; i < SMAX + 2; i++) begin
      do_cycle(1'b1, 1'b0, lit_mask());
      do_cycle(1'b0, 1'b1, '0);
    end
    check("score_saturated", 32'(score), 32'(SMAX));

    // Wrong presses drain the score to zero and no further.
    for (int i = 0; i < SMAX + 2; i++) begin
      unlit = ~lit_mask();
      do_cycle(1'b0, 1'b0, unlit);
    end
    check("penalty_floor", 32'(score), 32'd0);

    // Lit bit plus extra bits counts as exactly one hit.
    if (m_led < 0) do_cycle(1'b0, 1'b1, '0);
    sc0 = m_score;
    do_cycle(1'b0, 1'b0, '1);
    check("multi_bit_hit", 32'(score), 32'(sc0 + 1));

    // Hit coinciding with the final tick still counts.
    while (m_time > 1) do_cycle(1'b0, 1'b1, '0);
    sc0 = m_score;
    do_cycle(1'b0, 1'b1, lit_mask());
    check("final_tick_hit", 32'(score), 32'(sc0 < SMAX ? sc0 + 1 : SMAX));
    check("final_tick_over", 32'(game_over), 32'd1);
    do_cycle(1'b0, 1'b1, '1);

    // Reset mid-round with score 2.
    do_cycle(1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b1, '0);
    do_cycle(1'b0, 1'b0, lit_mask());
    do_cycle(1'b0, 1'b1, '0);
    do_cycle(1'b0, 1'b0, lit_mask());
    check("score_before_reset", 32'(score), 32'd2);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    do_cycle(1'b0, 1'b1, '1);
    reset = 1'b1;
    do_cycle(1'b0, 1'b1, '1);
    do_cycle(1'b0, 1'b1, '0);
    check("idle_after_reset", 32'(game_active), 32'd0);

    // Randomized play.
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 29) == 0);
      t = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 5);
      if (r == 0)      h = lit_mask();
      else if (r == 1) h = lit_mask() | NM'($urandom);
      else if (r == 2) h = NM'($urandom);
      else             h = '0;
      do_cycle(s, t, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/whackamole_core.md
WHACKAMOLE_CORE -- requirements
Module: whackamole_core

Interface
REQ-001 The block SHALL have parameter NUM_MOLES, default 5, meaning the number of mole positions (legal range 2..16).
REQ-002 The block SHALL have parameter SCORE_W, default 6, meaning the width of the score and miss counters.
REQ-003 The block SHALL have parameter GAME_TICKS, default 60, meaning the round length in ticks (legal range 1..255).
REQ-004 The block SHALL have parameter MOLE_LIFE, default 2, meaning the ticks a mole stays lit unhit (legal range 1..15).
REQ-005 The block SHALL have parameter PENALTY_EN, default 0, meaning that a wrong press decrements score when set to 1.
REQ-006 The block SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the non-zero LFSR reset value.
REQ-007 The block SHALL have port clock, input, 1 bit, the single system clock; all state SHALL be in this domain.
REQ-008 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1 bit, a single-cycle pulse from an already-debounced button.
REQ-010 The block SHALL have port tick, input, 1 bit, a single-cycle game-rate enable pulse.
REQ-011 The block SHALL have port hit, input, NUM_MOLES bits, per-position single-cycle debounced press pulses.
REQ-012 The block SHALL have port mole_led, output, NUM_MOLES bits, which is one-hot or zero.
REQ-013 The block SHALL have ports score and miss_count, outputs, SCORE_W bits each.
REQ-014 The block SHALL have port time_left, output, TW bits, where TW = clog2(GAME_TICKS+1).
REQ-015 The block SHALL have ports game_active and game_over, outputs, 1 bit each.

Function
REQ-016 The block SHALL register all outputs; no output SHALL depend combinationally on an input.
REQ-017 The FSM SHALL have states IDLE, PLAY and OVER; game_active SHALL be 1 only in PLAY, and game_over SHALL be 1 only in OVER.
REQ-018 On start in IDLE or OVER, at the next edge the FSM SHALL enter PLAY with time_left=GAME_TICKS, score=0, miss_count=0, mole_led=0 and the life counter at 0.
REQ-019 The block SHALL ignore start while in PLAY.
REQ-020 In PLAY, each tick SHALL decrement time_left; a tick taking time_left from 1 to 0 SHALL move the FSM to OVER and clear mole_led at the same edge.
REQ-021 A spawn SHALL occur on a PLAY tick when mole_led==0 and no hit is accepted in that cycle.
REQ-022 A spawn SHALL set one bit at index idx = lfsr[7:0] mod NUM_MOLES; if idx equals the previously lit index, the block SHALL use (idx+1) mod NUM_MOLES.
REQ-023 A spawn SHALL load the life counter with MOLE_LIFE.
REQ-024 On a PLAY tick with a mole lit and no hit, the life counter SHALL decrement; on reaching 0, miss_count SHALL increment (saturating) and a new mole SHALL spawn at the same edge.
REQ-025 A hit is accepted in PLAY when (hit & mole_led) != 0, in any cycle; score SHALL increment (saturating at 2^SCORE_W-1) and mole_led SHALL clear at that edge.
REQ-026 When hit has the lit bit and other bits set in the same cycle, the block SHALL count exactly one hit and no wrong press.
REQ-027 A wrong press is hit != 0 in PLAY with no overlap with mole_led; if PENALTY_EN=1, score SHALL decrement, saturating at 0; otherwise the press SHALL be ignored.
REQ-028 On hit and tick in the same cycle, the hit SHALL count, time_left SHALL decrement, and no spawn and no miss SHALL occur; the next spawn SHALL be on the following tick.
REQ-029 A hit coinciding with the final tick (time_left 1->0) SHALL still count.
REQ-030 The block SHALL ignore hit and tick in IDLE and OVER; score, miss_count and time_left SHALL hold in OVER until the next start.
REQ-031 A 16-bit Galois LFSR (taps 16,14,13,11) SHALL advance every clock in every state, and SHALL never reach the zero state.

Reset
REQ-032 While reset=0, the block SHALL asynchronously force state=IDLE, mole_led=0, score=0, miss_count=0, time_left=0, game_active=0, game_over=0, lfsr=LFSR_SEED, life=0 and previous index=0.
REQ-033 Assertion of reset mid-PLAY SHALL abandon the round with no partial update; after release, the block SHALL require a new start.

Verification
REQ-034 Scenario (GAME_TICKS=3): start, then 3 ticks with no hits -> game_active=1 at the edge after start; time_left 3,2,1,0; OVER with mole_led=0 and game_over=1.
REQ-035 Scenario (MOLE_LIFE=1): start, tick, hit on the lit bit one cycle later -> score=1, mole_led=0 at that edge, and the next tick spawns a different index.
REQ-036 Scenario (MOLE_LIFE=2): start, then 5 ticks with no hits -> miss_count=2, a new mole at each expiry, and no two consecutive identical indices.
REQ-037 Scenario (PENALTY_EN=1): score=1, press an unlit bit -> score=0; press an unlit bit again -> score stays 0; with PENALTY_EN=0 both presses leave score unchanged.
REQ-038 Scenario (SCORE_W=2): 4 accepted hits -> score saturates at 3; hit together with the final tick -> score counts and game_over=1.
REQ-039 Scenario: reset pulsed low mid-PLAY with score=2 -> all outputs 0 immediately, IDLE after release, and a tick or hit without start -> no change.
